rom_stream_reader: RTL and testbench

//  Sequential reader (initiator) for a combinational, single-cycle ROM.
//  On a start command it walks a run of consecutive ROM words starting at a base address.
//  It drives rom_addr, registers each returned word and presents it on a valid/ready output stream.

---
 rtl/rom_stream_reader.sv | 122 ++++++++++++
 tb/tb_rom_stream_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Walks a run of consecutive words in a combinational single-cycle ROM and
//   presents them on a valid/ready stream, one word per cycle while the
//   consumer keeps m_ready high.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, base_addr,  run command; base/length sampled only with start in IDLE
//   length             (length 0 = empty run, completes with a lone done pulse)
//   busy, done         busy in LOAD/STREAM; done pulses once per completed run
//   rom_addr, rom_data registered ROM address, combinational ROM word back
//   m_data, m_valid,   output stream; m_last flags the final word of the run
//   m_ready, m_last
module rom_stream_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            rom_addr_d  = base_addr;
            remaining_d = length;
            state_d     = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // rom_data reflects rom_addr_q this cycle; capture it and advance.
        m_data_d    = rom_data;
        m_valid_d   = 1'b1;
        m_last_d    = (remaining_q == ADDR_W'(1));
        rom_addr_d  = rom_addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        remaining_d = remaining_q - ADDR_W'(1);
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        // rom_addr_q already points at the next word, so a handshake can
        // refill the output register in the same cycle (full throughput).
        if (m_valid_q && m_ready) begin
          if (remaining_q != '0) begin
            m_data_d    = rom_data;
            m_valid_d   = 1'b1;
            m_last_d    = (remaining_q == ADDR_W'(1));
            rom_addr_d  = rom_addr_q + ADDR_W'(1);
            remaining_d = remaining_q - ADDR_W'(1);
          end else begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      done_q      <= done_d;
    end
  end

  assign busy     = (state_q == S_LOAD) || (state_q == S_STREAM);
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
//   Directed bench for rom_stream_reader with a combinational ROM model
//   rom_data = {20'hA5A5A, rom_addr}. Inputs change and outputs are sampled
//   1 time unit after each rising edge.
module tb_rom_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [11:0] length = '0;
  logic        busy, done, m_valid, m_last;
  logic        m_ready = 1'b0;
  logic [11:0] rom_addr;
  logic [31:0] rom_data, m_data;

  int n_chk = 0;
  int n_pass = 0;

  rom_stream_reader #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_data(rom_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  assign rom_data = {20'hA5A5A, rom_addr};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input string tag, input logic [31:0] d, input logic l);
    chk({tag, " valid"}, 64'(m_valid), 64'd1);
    chk({tag, " data"},  64'(m_data), 64'(d));
    chk({tag, " last"},  64'(m_last), 64'(l));
  endtask

  task automatic kick(input logic [11:0] b, input logic [11:0] n);
    base_addr = b; length = n; start = 1'b1;
    step();
    start = 1'b0; base_addr = 12'hBAD; length = 12'h777;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, " busy"},  64'(busy), 64'd0);
    chk({tag, " done"},  64'(done), 64'd0);
    chk({tag, " valid"}, 64'(m_valid), 64'd0);
    chk({tag, " last"},  64'(m_last), 64'd0);
    chk({tag, " addr"},  64'(rom_addr), 64'd0);
    chk({tag, " data"},  64'(m_data), 64'd0);
  endtask

  initial begin
    int words, dones;
    // 1. reset asserted from time 0, checked mid-clock before any edge
    #3;
    reset_vals("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // 2. base 0x004, len 3, consumer always ready
    m_ready = 1'b1;
    kick(12'h004, 12'd3);
    chk("t2 load busy", 64'(busy), 64'd1);
    chk("t2 load valid", 64'(m_valid), 64'd0);
    chk("t2 load addr", 64'(rom_addr), 64'h004);
    step(); word("t2 w0", 32'hA5A5A004, 1'b0);
    chk("t2 w0 done", 64'(done), 64'd0);
    step(); word("t2 w1", 32'hA5A5A005, 1'b0);
    step(); word("t2 w2", 32'hA5A5A006, 1'b1);
    step();
    chk("t2 done", 64'(done), 64'd1);
    chk("t2 valid off", 64'(m_valid), 64'd0);
    chk("t2 last off", 64'(m_last), 64'd0);
    chk("t2 busy off", 64'(busy), 64'd0);
    step();
    chk("t2 done pulse", 64'(done), 64'd0);

    // 3. base 0x010, len 2, back-pressure for 5 cycles
    m_ready = 1'b0;
    kick(12'h010, 12'd2);
    step();
    for (int i = 0; i < 5; i++) begin
      word("t3 stall", 32'hA5A5A010, 1'b0);
      chk("t3 stall addr", 64'(rom_addr), 64'h011);
      step();
    end
    m_ready = 1'b1;
    #1 word("t3 w0 hs", 32'hA5A5A010, 1'b0);
    step(); word("t3 w1", 32'hA5A5A011, 1'b1);
    step(); chk("t3 done", 64'(done), 64'd1);
    chk("t3 valid off", 64'(m_valid), 64'd0);

    // 4. address wrap: base 0xFFE, len 4
    kick(12'hFFE, 12'd4);
    step(); word("t4 w0", 32'hA5A5AFFE, 1'b0);
    step(); word("t4 w1", 32'hA5A5AFFF, 1'b0);
    step(); word("t4 w2", 32'hA5A5A000, 1'b0);
    step(); word("t4 w3", 32'hA5A5A001, 1'b1);
    step(); chk("t4 done", 64'(done), 64'd1);

    // 5a. empty run
    kick(12'h123, 12'd0);
    chk("t5 empty done", 64'(done), 64'd1);
    chk("t5 empty busy", 64'(busy), 64'd0);
    chk("t5 empty valid", 64'(m_valid), 64'd0);
    step();
    chk("t5 empty done pulse", 64'(done), 64'd0);
    chk("t5 empty valid2", 64'(m_valid), 64'd0);

    // 5b. start re-pulsed while busy must be ignored
    kick(12'h030, 12'd3);
    words = 0; dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        start = 1'b1; base_addr = 12'h100; length = 12'd7;
      end else begin
        start = 1'b0;
      end
      if (m_valid && m_ready) words++;
      if (done) dones++;
      step();
    end
    start = 1'b0;
    chk("t5 busy start words", 64'(words), 64'd3);
    chk("t5 busy start dones", 64'(dones), 64'd1);
    chk("t5 busy start idle", 64'(busy), 64'd0);

    // 6. async reset mid-run (after second handshake), then a len 1 run
    kick(12'h040, 12'd5);
    step(); word("t6 w0", 32'hA5A5A040, 1'b0);
    step(); word("t6 w1", 32'hA5A5A041, 1'b0);
    step(); word("t6 w2", 32'hA5A5A042, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_vals("t6 rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    reset_vals("t6 post");
    kick(12'h020, 12'd1);
    step(); word("t6 single", 32'hA5A5A020, 1'b1);
    step(); chk("t6 done", 64'(done), 64'd1);
    chk("t6 valid off", 64'(m_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
